ascii_dec_loader: RTL and testbench
===================================

# ascii_dec_loader

Receive-side counterpart to the memory-dump path. The memory-dump path reads banked block RAM and transmits each byte as ASCII decimal digits. This block parses the ASCII decimal byte stream arriving from `rxuart`, converts each delimited number to a binary value and writes it into the same bank-interleaved memory layout. It sits between `rxuart` (`o_wr`/`o_data`) and the `blk_mem_gen_0` port-A bank array, replacing raw byte loading.

## Interface
Parameters:
- `DATA_W`, default 8: width of stored words.
- `NBANKS`, default 4: number of memory banks; power of 2, ≥ 2. `BANK_W = $clog2(NBANKS)`.
- `DEPTH`, default 8: words per bank; power of 2. `ADDR_W = $clog2(DEPTH)`. `PTR_W = BANK_W + ADDR_W`.

Ports:
- `i_clk`, input, 1: the single clock.
- `i_reset`, input, 1: reset, synchronous and active-high.
- `i_wr`, input, 1: byte strobe from `rxuart`; one cycle per byte; may be asserted on consecutive cycles.
- `i_data`, input, 8: received byte, valid when `i_wr` = 1.
- `o_wr`, output, 1: one-cycle memory write strobe (drives `wea`).
- `o_bank_en`, output, NBANKS: one-hot bank enable, `1 << ptr[BANK_W-1:0]`; zero when `o_wr` = 0.
- `o_addr`, output, ADDR_W: in-bank address, `ptr[PTR_W-1:BANK_W]`.
- `o_data`, output, DATA_W: word to write.
- `o_ptr`, output, PTR_W: next write pointer.
- `o_err`, output, 1: sticky flag for an illegal character.
- `o_ovf`, output, 1: sticky flag for a saturated value.
- `o_wrapped`, output, 1: sticky flag set when the pointer wrapped.

## Operation
Character classes:
- Digit: 0x30–0x39.
- Delimiter: 0x20, 0x2C, 0x09, 0x0D, 0x0A.
- Sync: `#` (0x23).
- Minus: `-` (0x2D), legal only with the macro enabled.
- Illegal: everything else.

States:
- **S_IDLE** (between tokens):
  - digit → S_NUM, acc = digit.
  - delimiter → stay, no write.
  - minus → S_NEG.
  - illegal → set `o_err`, go to S_SKIP.
- **S_NUM** (accumulating):
  - digit → acc = acc×10 + digit.
  - delimiter → write acc, go to S_IDLE.
  - illegal → set `o_err`, go to S_SKIP; the partial value is discarded.
- **S_NEG** (minus seen, no digit yet):
  - digit → S_NUM with neg = 1.
  - delimiter → set `o_err`, go to S_IDLE, no write.
  - illegal → set `o_err`, go to S_SKIP.
- **S_SKIP**: discard bytes until a delimiter, then go to S_IDLE. No write.

Sync handling:
- `#` in any state: drop any partial token, set ptr = 0, clear `o_err`, `o_ovf` and `o_wrapped`, go to S_IDLE.

Arithmetic:
- The accumulator is DATA_W+4 bits wide.
- After each digit the accumulator is clamped to 2^DATA_W − 1 (2^(DATA_W−1) when neg = 1), and `o_ovf` is set on any clamp.
- Leading zeros are allowed.
- Negative values are stored as two's complement of the magnitude, truncated to DATA_W.

Pointer:
- Increments by 1 after each write.
- After NBANKS·DEPTH − 1 it wraps to 0 and sets `o_wrapped`.

The block has no end-of-stream detection: a token is written only when its delimiter arrives.

## Timing
- Each `i_wr` byte is fully processed in the cycle it is sampled. There is no backpressure.
- A delimiter sampled at edge N produces a registered `o_wr`, `o_bank_en`, `o_addr` and `o_data` valid for exactly the cycle after N (latency 1).
- `o_addr` and `o_bank_en` reflect the pre-increment pointer. `o_ptr` shows the post-increment value in the same cycle as `o_wr`.
- Back-to-back tokens: `3,4,` on consecutive cycles produce two `o_wr` pulses separated by one idle cycle.
- Sticky flags update in the cycle after the causing byte.
- Reset values: S_IDLE, acc = 0, neg = 0, ptr = 0, and `o_wr`, `o_bank_en`, `o_addr`, `o_data`, `o_err`, `o_ovf`, `o_wrapped` all 0.
- Reset asserted mid-token discards the token. If reset coincides with a delimiter, reset wins and no write occurs.

## Configuration
- `ASCII_DEC_NEG_EN` defined: minus handling and S_NEG exist as described above.
- `ASCII_DEC_NEG_EN` undefined:
  - `-` is illegal (sets `o_err`, goes to S_SKIP).
  - S_NEG and the neg flag are not synthesized.
  - The clamp is always 2^DATA_W − 1.

## Test plan
- Reset, then `"12 7,255\r"` → three writes:
  - 0x0C to bank 0, addr 0.
  - 0x07 to bank 1, addr 0.
  - 0xFF to bank 2, addr 0.
  - `o_ptr` = 3; all flags 0.
- `"300 "` → writes 0xFF and `o_ovf` = 1. Then `"#"` → `o_ovf` = 0 and `o_ptr` = 0.
- `"4x5 9 "` → `o_err` = 1; the token "4x5" is not written; exactly one write of 0x09 at ptr 0.
- 33 tokens `"1 "` with the default parameters → the 33rd write goes to bank 0, addr 0; `o_wrapped` = 1 from the 32nd write onward.
- With `ASCII_DEC_NEG_EN`: `"-5 -200 - "` → writes 0xFB and 0x80; `o_ovf` = 1; the lone `-` sets `o_err`.
- Assert `i_reset` on the same cycle as the `' '` following `"42"` → no `o_wr`; all outputs at their reset values.

Source files
------------

// File: rtl/ascii_dec_loader.sv
// ascii_dec_loader: parses an ASCII decimal byte stream (from rxuart) into
// binary words and writes them into a bank-interleaved block RAM layout.
// Optional feature macro: ASCII_DEC_NEG_EN enables '-' prefixed numbers,
// stored as two's complement of the (clamped) magnitude.
`timescale 1ns/1ps

module ascii_dec_loader #(
   parameter  int DATA_W = 8,
   parameter  int NBANKS = 4,
   parameter  int DEPTH  = 8,
   localparam int BANK_W = $clog2(NBANKS),
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int PTR_W  = BANK_W + ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wr,
   input  logic [7:0]        i_data,
   output logic              o_wr,
   output logic [NBANKS-1:0] o_bank_en,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic [PTR_W-1:0]  o_ptr,
   output logic              o_err,
   output logic              o_ovf,
   output logic              o_wrapped
);

   // Accumulator has 4 spare bits; the product is computed 4 bits wider
   // still so the clamp compare never loses carries.
   localparam int ACC_W  = DATA_W + 4;
   localparam int PROD_W = DATA_W + 8;
   localparam logic [PROD_W-1:0] MAX_POS = (PROD_W'(1) << DATA_W) - PROD_W'(1);
`ifdef ASCII_DEC_NEG_EN
   localparam logic [PROD_W-1:0] MAX_NEG = PROD_W'(1) << (DATA_W - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_NUM  = 2'd1,
`ifdef ASCII_DEC_NEG_EN
      S_NEG  = 2'd2,
`endif
      S_SKIP = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [ACC_W-1:0]    acc_reg, acc_next;
   logic [PTR_W-1:0]    ptr_reg, ptr_next;
   logic                err_reg, err_next;
   logic                ovf_reg, ovf_next;
   logic                wrapped_reg, wrapped_next;
   logic                wr_reg, wr_next;
   logic [NBANKS-1:0]   bank_en_reg, bank_en_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   data_reg, data_next;
`ifdef ASCII_DEC_NEG_EN
   logic                neg_reg, neg_next;
`endif

   // Character classification of the incoming byte.
   logic is_digit, is_delim, is_sync;
`ifdef ASCII_DEC_NEG_EN
   logic is_minus;
   assign is_minus = (i_data == 8'h2D);
`endif
   assign is_digit = (i_data >= 8'h30) && (i_data <= 8'h39);
   assign is_delim = (i_data == 8'h20) || (i_data == 8'h2C) || (i_data == 8'h09) ||
                     (i_data == 8'h0D) || (i_data == 8'h0A);
   assign is_sync  = (i_data == 8'h23);

   // Digit datapath: acc*10 + digit, starting from zero when not already
   // inside a number, then clamped to the sign-dependent limit.
   logic [ACC_W-1:0]  acc_base;
   logic [PROD_W-1:0] prod;
   logic [PROD_W-1:0] limit;
   logic              clamp_hit;
   logic [ACC_W-1:0]  acc_digit;
   logic [DATA_W-1:0] acc_lo;
   logic [DATA_W-1:0] word_out;

   assign acc_base = (state_reg == S_NUM) ? acc_reg : '0;
   assign prod     = PROD_W'(acc_base) * PROD_W'(10) + PROD_W'(i_data[3:0]);
`ifdef ASCII_DEC_NEG_EN
   assign limit    = ((state_reg == S_NEG) || ((state_reg == S_NUM) && neg_reg)) ? MAX_NEG : MAX_POS;
`else
   assign limit    = MAX_POS;
`endif
   assign clamp_hit = (prod > limit);
   assign acc_digit = clamp_hit ? limit[ACC_W-1:0] : prod[ACC_W-1:0];
   assign acc_lo    = acc_reg[DATA_W-1:0];
`ifdef ASCII_DEC_NEG_EN
   assign word_out  = neg_reg ? (~acc_lo + DATA_W'(1)) : acc_lo;
`else
   assign word_out  = acc_lo;
`endif

   // Next-state and output decode for one received byte.
   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      ptr_next     = ptr_reg;
      err_next     = err_reg;
      ovf_next     = ovf_reg;
      wrapped_next = wrapped_reg;
      wr_next      = 1'b0;
      bank_en_next = '0;
      addr_next    = addr_reg;
      data_next    = data_reg;
`ifdef ASCII_DEC_NEG_EN
      neg_next     = neg_reg;
`endif
      if (i_wr) begin
         if (is_sync) begin
            // Resynchronise: drop the token and restart the load at word 0.
            state_next   = S_IDLE;
            acc_next     = '0;
            ptr_next     = '0;
            err_next     = 1'b0;
            ovf_next     = 1'b0;
            wrapped_next = 1'b0;
`ifdef ASCII_DEC_NEG_EN
            neg_next     = 1'b0;
`endif
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if (is_digit) begin
                     state_next = S_NUM;
                     acc_next   = acc_digit;
                     if (clamp_hit) ovf_next = 1'b1;
`ifdef ASCII_DEC_NEG_EN
                     neg_next   = 1'b0;
`endif
                  end else if (is_delim) begin
                     state_next = S_IDLE;
`ifdef ASCII_DEC_NEG_EN
                  end else if (is_minus) begin
                     state_next = S_NEG;
`endif
                  end else begin
                     err_next   = 1'b1;
                     state_next = S_SKIP;
                  end
               end
               S_NUM: begin
                  if (is_digit) begin
                     acc_next = acc_digit;
                     if (clamp_hit) ovf_next = 1'b1;
                  end else if (is_delim) begin
                     // Commit the word at the current pointer, then advance.
                     wr_next      = 1'b1;
                     bank_en_next = NBANKS'(1) << ptr_reg[BANK_W-1:0];
                     addr_next    = ptr_reg[PTR_W-1:BANK_W];
                     data_next    = word_out;
                     ptr_next     = ptr_reg + PTR_W'(1);
                     if (ptr_reg == '1) wrapped_next = 1'b1;
                     acc_next     = '0;
                     state_next   = S_IDLE;
`ifdef ASCII_DEC_NEG_EN
                     neg_next     = 1'b0;
`endif
                  end else begin
                     err_next   = 1'b1;
                     acc_next   = '0;
                     state_next = S_SKIP;
`ifdef ASCII_DEC_NEG_EN
                     neg_next   = 1'b0;
`endif
                  end
               end
`ifdef ASCII_DEC_NEG_EN
               S_NEG: begin
                  if (is_digit) begin
                     state_next = S_NUM;
                     acc_next   = acc_digit;
                     neg_next   = 1'b1;
                     if (clamp_hit) ovf_next = 1'b1;
                  end else if (is_delim) begin
                     err_next   = 1'b1;
                     state_next = S_IDLE;
                  end else begin
                     err_next   = 1'b1;
                     state_next = S_SKIP;
                  end
               end
`endif
               S_SKIP: begin
                  if (is_delim) state_next = S_IDLE;
               end
               default: begin
                  state_next = S_IDLE;
                  acc_next   = '0;
               end
            endcase
         end
      end
   end

   // State, datapath and registered write-port outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg   <= S_IDLE;
         acc_reg     <= '0;
         ptr_reg     <= '0;
         err_reg     <= 1'b0;
         ovf_reg     <= 1'b0;
         wrapped_reg <= 1'b0;
         wr_reg      <= 1'b0;
         bank_en_reg <= '0;
         addr_reg    <= '0;
         data_reg    <= '0;
`ifdef ASCII_DEC_NEG_EN
         neg_reg     <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         ptr_reg     <= ptr_next;
         err_reg     <= err_next;
         ovf_reg     <= ovf_next;
         wrapped_reg <= wrapped_next;
         wr_reg      <= wr_next;
         bank_en_reg <= bank_en_next;
         addr_reg    <= addr_next;
         data_reg    <= data_next;
`ifdef ASCII_DEC_NEG_EN
         neg_reg     <= neg_next;
`endif
      end
   end

   assign o_wr      = wr_reg;
   assign o_bank_en = bank_en_reg;
   assign o_addr    = addr_reg;
   assign o_data    = data_reg;
   assign o_ptr     = ptr_reg;
   assign o_err     = err_reg;
   assign o_ovf     = ovf_reg;
   assign o_wrapped = wrapped_reg;

endmodule

// File: tb/tb_ascii_dec_loader.sv
// tb_ascii_dec_loader: directed self-checking bench for ascii_dec_loader
// (default parameters; negative-number test depends on ASCII_DEC_NEG_EN).
`timescale 1ns/1ps

module tb_ascii_dec_loader;

   logic       i_clk;
   logic       i_reset;
   logic       i_wr;
   logic [7:0] i_data;
   logic       o_wr;
   logic [3:0] o_bank_en;
   logic [2:0] o_addr;
   logic [7:0] o_data;
   logic [4:0] o_ptr;
   logic       o_err;
   logic       o_ovf;
   logic       o_wrapped;

   int n_pass  = 0;
   int n_total = 0;

   // Writes observed after each byte, in order.
   logic [3:0] cap_bank[$];
   logic [2:0] cap_addr[$];
   logic [7:0] cap_data[$];
   logic [4:0] cap_ptr[$];
   logic       cap_wrapped[$];
   logic       last_wr;

   ascii_dec_loader #(.DATA_W(8), .NBANKS(4), .DEPTH(8)) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_wr      (i_wr),
      .i_data    (i_data),
      .o_wr      (o_wr),
      .o_bank_en (o_bank_en),
      .o_addr    (o_addr),
      .o_data    (o_data),
      .o_ptr     (o_ptr),
      .o_err     (o_err),
      .o_ovf     (o_ovf),
      .o_wrapped (o_wrapped)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic clear_caps();
      cap_bank.delete();
      cap_addr.delete();
      cap_data.delete();
      cap_ptr.delete();
      cap_wrapped.delete();
   endtask

   // Present one byte for one clock, then look at the registered outputs 1ns later.
   task automatic send_byte(input logic [7:0] b);
      i_wr   = 1'b1;
      i_data = b;
      @(posedge i_clk);
      #1;
      i_wr   = 1'b0;
      i_data = 8'h00;
      last_wr = o_wr;
      if (o_wr === 1'b1) begin
         cap_bank.push_back(o_bank_en);
         cap_addr.push_back(o_addr);
         cap_data.push_back(o_data);
         cap_ptr.push_back(o_ptr);
         cap_wrapped.push_back(o_wrapped);
         $display("write bank_en=%b addr=%0d data=0x%02h ptr=%0d", o_bank_en, o_addr, o_data, o_ptr);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic idle_cycle();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      i_wr    = 1'b0;
      i_data  = 8'h00;
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      n_total++; if ({o_wr, o_bank_en, o_addr, o_data} !== 16'h0) $display("FAIL reset_wr_port got %h want 0", {o_wr, o_bank_en, o_addr, o_data}); else n_pass++;
      n_total++; if (o_ptr !== 5'd0) $display("FAIL reset_ptr got %0d want 0", o_ptr); else n_pass++;
      n_total++; if ({o_err, o_ovf, o_wrapped} !== 3'b000) $display("FAIL reset_flags got %b want 000", {o_err, o_ovf, o_wrapped}); else n_pass++;
   endtask

   task automatic test_basic();
      clear_caps();
      send_str("12 7,255\r");
      n_total++; if (cap_data.size() !== 3) $display("FAIL basic_count got %0d want 3", cap_data.size()); else n_pass++;
      n_total++; if ({cap_bank[0], cap_addr[0], cap_data[0]} !== {4'b0001, 3'd0, 8'h0C}) $display("FAIL basic_w0 got %b/%0d/%h want 0001/0/0c", cap_bank[0], cap_addr[0], cap_data[0]); else n_pass++;
      n_total++; if (cap_ptr[0] !== 5'd1) $display("FAIL basic_ptr_post got %0d want 1", cap_ptr[0]); else n_pass++;
      n_total++; if ({cap_bank[1], cap_addr[1], cap_data[1]} !== {4'b0010, 3'd0, 8'h07}) $display("FAIL basic_w1 got %b/%0d/%h want 0010/0/07", cap_bank[1], cap_addr[1], cap_data[1]); else n_pass++;
      n_total++; if ({cap_bank[2], cap_addr[2], cap_data[2]} !== {4'b0100, 3'd0, 8'hFF}) $display("FAIL basic_w2 got %b/%0d/%h want 0100/0/ff", cap_bank[2], cap_addr[2], cap_data[2]); else n_pass++;
      idle_cycle();
      n_total++; if (o_wr !== 1'b0) $display("FAIL basic_wr_drop got %b want 0", o_wr); else n_pass++;
      n_total++; if (o_ptr !== 5'd3) $display("FAIL basic_ptr got %0d want 3", o_ptr); else n_pass++;
      n_total++; if ({o_err, o_ovf, o_wrapped} !== 3'b000) $display("FAIL basic_flags got %b want 000", {o_err, o_ovf, o_wrapped}); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] pattern;
      clear_caps();
      send_byte("3"); pattern[3] = last_wr;
      send_byte(","); pattern[2] = last_wr;
      send_byte("0"); pattern[1] = last_wr;
      send_byte("4"); pattern[1] = pattern[1] | last_wr;
      send_byte(","); pattern[0] = last_wr;
      n_total++; if (pattern !== 4'b0101) $display("FAIL b2b_pulses got %b want 0101", pattern); else n_pass++;
      n_total++; if ({cap_bank[0], cap_addr[0], cap_data[0]} !== {4'b1000, 3'd0, 8'h03}) $display("FAIL b2b_w0 got %b/%0d/%h want 1000/0/03", cap_bank[0], cap_addr[0], cap_data[0]); else n_pass++;
      n_total++; if ({cap_bank[1], cap_addr[1], cap_data[1]} !== {4'b0001, 3'd1, 8'h04}) $display("FAIL b2b_w1 got %b/%0d/%h want 0001/1/04", cap_bank[1], cap_addr[1], cap_data[1]); else n_pass++;
   endtask

   task automatic test_overflow_sync();
      clear_caps();
      send_str("300 ");
      n_total++; if (cap_data.size() !== 1 || cap_data[0] !== 8'hFF) $display("FAIL ovf_value got n=%0d data=%h want n=1 data=ff", cap_data.size(), cap_data[0]); else n_pass++;
      n_total++; if (o_ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", o_ovf); else n_pass++;
      send_str("#");
      n_total++; if (o_ovf !== 1'b0) $display("FAIL sync_ovf_clear got %b want 0", o_ovf); else n_pass++;
      n_total++; if (o_ptr !== 5'd0) $display("FAIL sync_ptr got %0d want 0", o_ptr); else n_pass++;
      n_total++; if (o_wr !== 1'b0) $display("FAIL sync_no_write got %b want 0", o_wr); else n_pass++;
   endtask

   task automatic test_illegal();
      clear_caps();
      send_str("4x5 9 ");
      n_total++; if (o_err !== 1'b1) $display("FAIL illegal_err got %b want 1", o_err); else n_pass++;
      n_total++; if (cap_data.size() !== 1) $display("FAIL illegal_count got %0d want 1", cap_data.size()); else n_pass++;
      n_total++; if ({cap_bank[0], cap_addr[0], cap_data[0]} !== {4'b0001, 3'd0, 8'h09}) $display("FAIL illegal_w0 got %b/%0d/%h want 0001/0/09", cap_bank[0], cap_addr[0], cap_data[0]); else n_pass++;
      send_str("#");
      n_total++; if (o_err !== 1'b0) $display("FAIL sync_err_clear got %b want 0", o_err); else n_pass++;
   endtask

   task automatic test_leading_zero();
      clear_caps();
      send_str("007\t");
      n_total++; if (cap_data.size() !== 1 || cap_data[0] !== 8'h07) $display("FAIL lead_zero got n=%0d data=%h want n=1 data=07", cap_data.size(), cap_data[0]); else n_pass++;
      send_str("#");
   endtask

   task automatic test_wrap();
      clear_caps();
      for (int k = 0; k < 33; k++) send_str("1 ");
      n_total++; if (cap_data.size() !== 33) $display("FAIL wrap_count got %0d want 33", cap_data.size()); else n_pass++;
      n_total++; if (cap_wrapped[30] !== 1'b0) $display("FAIL wrap_31st got %b want 0", cap_wrapped[30]); else n_pass++;
      n_total++; if (cap_wrapped[31] !== 1'b1 || cap_wrapped[32] !== 1'b1) $display("FAIL wrap_32nd_33rd got %b%b want 11", cap_wrapped[31], cap_wrapped[32]); else n_pass++;
      n_total++; if ({cap_bank[31], cap_addr[31], cap_ptr[31]} !== {4'b1000, 3'd7, 5'd0}) $display("FAIL wrap_w32 got %b/%0d/%0d want 1000/7/0", cap_bank[31], cap_addr[31], cap_ptr[31]); else n_pass++;
      n_total++; if ({cap_bank[32], cap_addr[32], cap_data[32]} !== {4'b0001, 3'd0, 8'h01}) $display("FAIL wrap_w33 got %b/%0d/%h want 0001/0/01", cap_bank[32], cap_addr[32], cap_data[32]); else n_pass++;
      n_total++; if (o_ptr !== 5'd1) $display("FAIL wrap_ptr got %0d want 1", o_ptr); else n_pass++;
      send_str("#");
   endtask

   task automatic test_minus();
      clear_caps();
`ifdef ASCII_DEC_NEG_EN
      send_str("-5 -200 - ");
      n_total++; if (cap_data.size() !== 2) $display("FAIL neg_count got %0d want 2", cap_data.size()); else n_pass++;
      n_total++; if (cap_data[0] !== 8'hFB || cap_data[1] !== 8'h80) $display("FAIL neg_values got %h,%h want fb,80", cap_data[0], cap_data[1]); else n_pass++;
      n_total++; if ({o_ovf, o_err} !== 2'b11) $display("FAIL neg_flags got ovf,err=%b want 11", {o_ovf, o_err}); else n_pass++;
`else
      send_str("-5 7 ");
      n_total++; if (cap_data.size() !== 1 || cap_data[0] !== 8'h07) $display("FAIL minus_illegal_write got n=%0d data=%h want n=1 data=07", cap_data.size(), cap_data[0]); else n_pass++;
      n_total++; if (o_err !== 1'b1) $display("FAIL minus_illegal_err got %b want 1", o_err); else n_pass++;
`endif
      send_str("#");
   endtask

   task automatic test_reset_mid_token();
      clear_caps();
      send_str("9 42");
      i_reset = 1'b1;
      i_wr    = 1'b1;
      i_data  = " ";
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      i_wr    = 1'b0;
      i_data  = 8'h00;
      n_total++; if (o_wr !== 1'b0) $display("FAIL rst_delim_wr got %b want 0", o_wr); else n_pass++;
      n_total++; if ({o_bank_en, o_addr, o_data, o_ptr, o_err, o_ovf, o_wrapped} !== 23'h0) $display("FAIL rst_delim_outputs got %h want 0", {o_bank_en, o_addr, o_data, o_ptr, o_err, o_ovf, o_wrapped}); else n_pass++;
      clear_caps();
      send_str("5 ");
      n_total++; if (cap_data.size() !== 1 || {cap_bank[0], cap_addr[0], cap_data[0]} !== {4'b0001, 3'd0, 8'h05}) $display("FAIL rst_after_write got n=%0d %b/%0d/%h want 0001/0/05", cap_data.size(), cap_bank[0], cap_addr[0], cap_data[0]); else n_pass++;
   endtask

   initial begin
      i_reset = 1'b1;
      i_wr    = 1'b0;
      i_data  = 8'h00;
      last_wr = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow_sync();
      test_illegal();
      test_leading_zero();
      test_wrap();
      test_minus();
      test_reset_mid_token();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
